// File: rtl/raster_walker.sv
// raster_walker: walks a triangle bounding box in raster order, one pixel per
// clock, stepping three edge functions incrementally and emitting covered
// pixels as fragments on a valid/ready stream.
module raster_walker #(
    parameter int INCLUSIVE = 1,
    parameter int CW        = 16,
    parameter int EW        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [CW-1:0] xmin,
    input  logic signed [CW-1:0] xmax,
    input  logic signed [CW-1:0] ymin,
    input  logic signed [CW-1:0] ymax,
    input  logic signed [EW-1:0] e1_0,
    input  logic signed [EW-1:0] e2_0,
    input  logic signed [EW-1:0] e3_0,
    input  logic signed [EW-1:0] sx1,
    input  logic signed [EW-1:0] sx2,
    input  logic signed [EW-1:0] sx3,
    input  logic signed [EW-1:0] sy1,
    input  logic signed [EW-1:0] sy2,
    input  logic signed [EW-1:0] sy3,
    output logic                 frag_valid,
    input  logic                 frag_ready,
    output logic signed [CW-1:0] frag_x,
    output logic signed [CW-1:0] frag_y,
    output logic signed [EW-1:0] frag_e1,
    output logic signed [EW-1:0] frag_e2,
    output logic signed [EW-1:0] frag_e3,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state, state_next;

    logic signed [CW-1:0] x_min_r, x_max_r, y_max_r;
    logic signed [CW-1:0] cur_x, cur_y;
    logic signed [EW-1:0] sx1_r, sx2_r, sx3_r, sy1_r, sy2_r, sy3_r;
    logic signed [EW-1:0] cur_e1, cur_e2, cur_e3;
    logic signed [EW-1:0] row_e1, row_e2, row_e3;

    logic       slot_free, covered, last_col, last_row, empty_box;
    logic [2:0] nonneg, positive;

    // Coverage test and scan-position flags for the current pixel
    always_comb begin
        nonneg    = {~cur_e1[EW-1], ~cur_e2[EW-1], ~cur_e3[EW-1]};
        positive  = nonneg & {|cur_e1, |cur_e2, |cur_e3};
        covered   = (INCLUSIVE != 0) ? &nonneg : &positive;
        slot_free = !frag_valid || frag_ready;
        last_col  = (cur_x == x_max_r);
        last_row  = (cur_y == y_max_r);
        empty_box = (xmin > xmax) || (ymin > ymax);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = empty_box ? FLUSH : SCAN;
            SCAN:    if (slot_free && last_col && last_row) state_next = FLUSH;
            FLUSH:   if (slot_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (state == SCAN) || (state == FLUSH);
    end

    // Datapath: triangle latch, incremental edge stepping, fragment register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_min_r    <= '0;
            x_max_r    <= '0;
            y_max_r    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            sx1_r      <= '0;
            sx2_r      <= '0;
            sx3_r      <= '0;
            sy1_r      <= '0;
            sy2_r      <= '0;
            sy3_r      <= '0;
            cur_e1     <= '0;
            cur_e2     <= '0;
            cur_e3     <= '0;
            row_e1     <= '0;
            row_e2     <= '0;
            row_e3     <= '0;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            frag_e1    <= '0;
            frag_e2    <= '0;
            frag_e3    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_min_r <= xmin;
                        x_max_r <= xmax;
                        y_max_r <= ymax;
                        cur_x   <= xmin;
                        cur_y   <= ymin;
                        sx1_r   <= sx1;
                        sx2_r   <= sx2;
                        sx3_r   <= sx3;
                        sy1_r   <= sy1;
                        sy2_r   <= sy2;
                        sy3_r   <= sy3;
                        cur_e1  <= e1_0;
                        cur_e2  <= e2_0;
                        cur_e3  <= e3_0;
                        row_e1  <= e1_0;
                        row_e2  <= e2_0;
                        row_e3  <= e3_0;
                    end
                end
                SCAN: begin
                    if (slot_free) begin
                        frag_valid <= covered;
                        if (covered) begin
                            frag_x  <= cur_x;
                            frag_y  <= cur_y;
                            frag_e1 <= cur_e1;
                            frag_e2 <= cur_e2;
                            frag_e3 <= cur_e3;
                        end
                        if (!last_col) begin
                            cur_x  <= cur_x + CW'(1);
                            cur_e1 <= cur_e1 + sx1_r;
                            cur_e2 <= cur_e2 + sx2_r;
                            cur_e3 <= cur_e3 + sx3_r;
                        end else if (!last_row) begin
                            cur_x  <= x_min_r;
                            cur_y  <= cur_y + CW'(1);
                            row_e1 <= row_e1 + sy1_r;
                            row_e2 <= row_e2 + sy2_r;
                            row_e3 <= row_e3 + sy3_r;
                            cur_e1 <= row_e1 + sy1_r;
                            cur_e2 <= row_e2 + sy2_r;
                            cur_e3 <= row_e3 + sy3_r;
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        frag_valid <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_walker.sv
// Testbench for raster_walker: two instances (inclusive and strict coverage)
// share stimulus; a reference model fills per-instance fragment queues that
// are popped on every observed handshake.
module tb_raster_walker;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [31:0] e1;
        logic signed [31:0] e2;
        logic signed [31:0] e3;
    } frag_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, ready;
    logic signed [15:0] xmin, xmax, ymin, ymax;
    logic signed [31:0] e1_0, e2_0, e3_0, sx1, sx2, sx3, sy1, sy2, sy3;

    logic [1:0]        fv, dn, bs;
    logic [1:0][15:0]  fx, fy;
    logic [1:0][31:0]  fe1, fe2, fe3;

    raster_walker #(.INCLUSIVE(1), .CW(16), .EW(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .e1_0(e1_0), .e2_0(e2_0), .e3_0(e3_0),
        .sx1(sx1), .sx2(sx2), .sx3(sx3), .sy1(sy1), .sy2(sy2), .sy3(sy3),
        .frag_valid(fv[1]), .frag_ready(ready),
        .frag_x(fx[1]), .frag_y(fy[1]),
        .frag_e1(fe1[1]), .frag_e2(fe2[1]), .frag_e3(fe3[1]),
        .busy(bs[1]), .done(dn[1])
    );

    raster_walker #(.INCLUSIVE(0), .CW(16), .EW(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .e1_0(e1_0), .e2_0(e2_0), .e3_0(e3_0),
        .sx1(sx1), .sx2(sx2), .sx3(sx3), .sy1(sy1), .sy2(sy2), .sy3(sy3),
        .frag_valid(fv[0]), .frag_ready(ready),
        .frag_x(fx[0]), .frag_y(fy[0]),
        .frag_e1(fe1[0]), .frag_e2(fe2[0]), .frag_e3(fe3[0]),
        .busy(bs[0]), .done(dn[0])
    );

    frag_t q1[$];
    frag_t q0[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int s_cyc = 0;
    int done_at = -1;
    int dn1_cnt = 0;
    int dn0_cnt = 0;
    int busy_cnt = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_a();
        xmin = 0; xmax = 3; ymin = 0; ymax = 3;
        e1_0 = 0; sx1 = 1;  sy1 = 0;
        e2_0 = 0; sx2 = 0;  sy2 = 1;
        e3_0 = 3; sx3 = -1; sy3 = -1;
    endtask

    // Reference model: direct evaluation of each pixel's edge values
    task automatic build();
        int a, b, c;
        q1.delete();
        q0.delete();
        for (int y = int'(ymin); y <= int'(ymax); y++) begin
            for (int x = int'(xmin); x <= int'(xmax); x++) begin
                a = int'(e1_0) + (x - int'(xmin)) * int'(sx1) + (y - int'(ymin)) * int'(sy1);
                b = int'(e2_0) + (x - int'(xmin)) * int'(sx2) + (y - int'(ymin)) * int'(sy2);
                c = int'(e3_0) + (x - int'(xmin)) * int'(sx3) + (y - int'(ymin)) * int'(sy3);
                if (a >= 0 && b >= 0 && c >= 0)
                    q1.push_back({16'(x), 16'(y), 32'(a), 32'(b), 32'(c)});
                if (a > 0 && b > 0 && c > 0)
                    q0.push_back({16'(x), 16'(y), 32'(a), 32'(b), 32'(c)});
            end
        end
    endtask

    task automatic pop_check(input int i);
        frag_t exp;
        int sz;
        sz = (i == 1) ? q1.size() : q0.size();
        check($sformatf("frag_expected_inst%0d", i), 160'(sz > 0), 160'(1));
        if (sz > 0) begin
            exp = (i == 1) ? q1.pop_front() : q0.pop_front();
            check($sformatf("frag_fields_inst%0d", i),
                  {fx[i], fy[i], fe1[i], fe2[i], fe3[i]}, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            if (fv[i] && ready) pop_check(i);
        if (dn[1]) begin
            dn1_cnt++;
            if (done_at < 0) done_at = cyc - s_cyc;
        end
        if (dn[0]) dn0_cnt++;
        if (bs[1]) busy_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_tri();
        dn1_cnt = 0; dn0_cnt = 0; busy_cnt = 0; done_at = -1;
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_tri(input string tag, input int exp_done_at, input int exp_busy);
        for (int k = 0; k < 80 && !(dn1_cnt > 0 && dn0_cnt > 0); k++) tick();
        repeat (3) tick();
        check({tag, "_done_at"},    160'(done_at),    160'(exp_done_at));
        check({tag, "_done1_cnt"},  160'(dn1_cnt),    160'(1));
        check({tag, "_done0_cnt"},  160'(dn0_cnt),    160'(1));
        check({tag, "_busy_cycles"}, 160'(busy_cnt),  160'(exp_busy));
        check({tag, "_q1_left"},    160'(q1.size()),  160'(0));
        check({tag, "_q0_left"},    160'(q0.size()),  160'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        set_a();
        repeat (2) tick();
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs_inst%0d", i),
                  160'({fv[i], fx[i], fy[i], fe1[i], fe2[i], fe3[i], dn[i], bs[i]}), '0);
        rst_n = 1'b1;
        tick();

        // Triangle A with ready held high
        build();
        check("model_count_incl", 160'(q1.size()), 160'(10));
        begin_tri();
        finish_tri("tri_a", 18, 17);

        // Triangle A with a 5-cycle stall on fragment (1,0)
        build();
        begin_tri();
        for (int k = 0; k < 20; k++) begin
            if (fv[1] && fx[1] == 16'd1 && fy[1] == 16'd0) break;
            tick();
        end
        ready = 1'b0;
        repeat (5) begin
            check("stall_hold", 160'({fv[1], fx[1], fy[1], fe1[1], fe2[1], fe3[1]}),
                  160'({1'b1, q1[0]}));
            tick();
        end
        ready = 1'b1;
        finish_tri("stall", 23, 22);

        // Empty bounding box
        xmin = 2; xmax = 1;
        build();
        begin_tri();
        finish_tri("empty", 2, 1);
        set_a();

        // start re-pulsed mid-scan with different inputs
        build();
        begin_tri();
        repeat (3) tick();
        xmin = -4; xmax = 1; ymax = 7; e1_0 = 100; e3_0 = -9; sx1 = 5; sy2 = -2;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_tri("repulse", 18, 17);
        set_a();

        // Reset mid-scan abandons the triangle
        build();
        begin_tri();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++)
            check($sformatf("midreset_outputs_inst%0d", i),
                  160'({fv[i], fx[i], fy[i], fe1[i], fe2[i], fe3[i], dn[i], bs[i]}), '0);
        repeat (4) tick();
        check("midreset_no_done", 160'(dn1_cnt + dn0_cnt), 160'(0));
        build();
        begin_tri();
        finish_tri("after_reset", 18, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raster_walker.md
Name: raster_walker

Overview:
- Sequential consumer of per-triangle edge-function setup: start-pixel edge values plus per-pixel and per-row increments.
- Walks the triangle bounding box in raster order, one pixel per clock, by incremental addition (no multipliers).
- Emits only covered pixels as fragments on a valid/ready stream toward shading/framebuffer write.

Parameters:
INCLUSIVE, 1, 1: pixel covered when all three edges >= 0; 0: covered only when all three > 0
CW, 16, coordinate width (signed)
EW, 32, edge value / increment width (signed)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a triangle; sampled only in IDLE
xmin, xmax, ymin, ymax  in  CW each  bounding box, signed, inclusive
e1_0, e2_0, e3_0  in  EW each  edge values at pixel (xmin,ymin)
sx1, sx2, sx3  in  EW each  edge increment per +1 x
sy1, sy2, sy3  in  EW each  edge increment per +1 y
frag_valid  out  1  fragment available
frag_ready  in  1  downstream accepts fragment
frag_x, frag_y  out  CW each  fragment coordinates
frag_e1, frag_e2, frag_e3  out  EW each  edge values at fragment (for barycentrics)
busy  out  1  high in SCAN and FLUSH
done  out  1  one-cycle pulse: triangle fully emitted

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; all outputs 0; internal registers cleared. Reset mid-scan abandons the triangle immediately; no done pulse.
- States: IDLE, SCAN, FLUSH.
- IDLE:
  - On start, latch bbox, increments, and edge values.
  - Load current and row-start edge registers with e*_0; set cur x/y = xmin/ymin.
  - Go to SCAN, or to FLUSH if xmin > xmax or ymin > ymax (signed compare).
- start outside IDLE is ignored; latched inputs are never re-sampled mid-triangle.
- Output slot is free when !frag_valid || frag_ready.
- SCAN, per cycle with slot free:
  - Evaluate current pixel. Covered: all three cur edges >= 0 (INCLUSIVE=1) or > 0 (INCLUSIVE=0).
  - If covered: register frag_x/y/e* from current values and set frag_valid=1; otherwise frag_valid=0 (when slot was freed by handshake).
  - Advance, x < xmax: x += 1; cur_e* += sx*.
  - Advance, x == xmax and y < ymax: x = xmin; y += 1; row_e* += sy*; cur_e* = row_e* + sy*.
  - Advance, x == xmax and y == ymax: go to FLUSH.
- SCAN with slot not free: stall. Pixel position, edge registers, and all frag_* outputs hold stable.
- frag_* fields must not change while frag_valid && !frag_ready.
- FLUSH: when slot free, clear frag_valid (unless holding), go to IDLE, and assert done for exactly one cycle.
- Timing: FLUSH is entered with the last fragment possibly pending; done follows that fragment's handshake.
- Throughput: 1 pixel evaluated per clock with frag_ready=1.
- Latency: first pixel evaluated in the clock after start is sampled; its fragment is visible 2 clocks after start.
- Bbox of N pixels with frag_ready tied 1: done high N+2 clocks after start sampled.
- Empty bbox: no fragments; done 2 clocks after start.
- Arithmetic: EW-bit two's complement add, wrap-around, no saturation. Coordinate increments never exceed xmax/ymax, so no CW overflow for legal bboxes.
- Single-pixel bbox (xmin==xmax, ymin==ymax): exactly one evaluation, then FLUSH.

Test Plan:
- Bbox 0..3 x 0..3; e1_0=0,sx1=1,sy1=0; e2_0=0,sx2=0,sy2=1; e3_0=3,sx3=-1,sy3=-1; INCLUSIVE=1; ready=1 -> 10 fragments in order (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(0,2)(1,2)(0,3). First has e=(0,0,3); last (0,3) has e=(0,3,0). done once, 18 clocks after start.
- Same setup, INCLUSIVE=0 -> single fragment (1,1) with e=(1,1,1); done once.
- Same setup, frag_ready low for 5 cycles while frag_valid holds (1,0) -> frag_x/y/e* stable for all 5 cycles. Resumes with (2,0); no fragment lost or duplicated; total still 10.
- xmin=2, xmax=1 -> frag_valid never high; done pulses 2 clocks after start; busy high 1 cycle.
- start re-pulsed during SCAN with different inputs -> ignored; output sequence matches first triangle.
- rst_n low for 1 cycle mid-scan -> next cycle all outputs 0, state IDLE, no done. A new start then runs the first scenario correctly.
